nes_joypad_port: RTL and testbench

- CPU-bus responder for the NES controller registers: write $4016 (strobe), read $4016 (pad 0) and $4017 (pad 1).
- Answers the accesses the 6502 core initiates; output data is muxed into the core's DIN.
- Contains a poll engine that reads two external NES pads over the latch/clock/data wire protocol and keeps a button snapshot.
- Button bit order, bit0 first: A, B, Select, Start, Up, Down, Left, Right.

---
 rtl/nes_io_pkg.sv | 42 ++++
 rtl/nes_pad_poller.sv | 159 +++++++++++++++
 rtl/nes_joypad_port.sv | 96 +++++++++
 tb/tb_nes_joypad_port.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_io_pkg.sv
// Shared NES I/O definitions: controller register addresses, button indices, poll FSM states.
// Also holds the D-pad filter helper used when JOYPAD_DPAD_FILTER_EN is defined.
package nes_io_pkg;

    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [2:0] OPEN_BUS = 3'b010;

    typedef enum logic [2:0] {
        POLL_IDLE,
        POLL_LATCH,
        POLL_CLK_LO,
        POLL_CLK_HI,
        POLL_DONE
    } poll_state_t;

    // Opposing directions cannot be pressed together on a real pad; treat that as neither.
    function automatic logic [7:0] dpad_filter(input logic [7:0] i_btn);
        logic [7:0] w_res;
        w_res = i_btn;
        if (i_btn[BTN_UP] && i_btn[BTN_DOWN]) begin
            w_res[BTN_UP]   = 1'b0;
            w_res[BTN_DOWN] = 1'b0;
        end
        if (i_btn[BTN_LEFT] && i_btn[BTN_RIGHT]) begin
            w_res[BTN_LEFT]  = 1'b0;
            w_res[BTN_RIGHT] = 1'b0;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/nes_pad_poller.sv
// Periodic poll engine reading two NES pads over latch/clock/data and keeping a button snapshot.
// Build option: JOYPAD_DPAD_FILTER_EN drops opposing D-pad pairs before the snapshot is stored.
module nes_pad_poller
    import nes_io_pkg::*;
#(
    parameter int CLK_DIV       = 100,
    parameter int POLL_INTERVAL = 357954
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_pad_data0,
    input  logic       i_pad_data1,
    output logic       o_pad_latch,
    output logic       o_pad_clk,
    output logic [7:0] o_buttons0,
    output logic [7:0] o_buttons1
);

    localparam int             PCW       = $clog2(POLL_INTERVAL + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_INTERVAL - 1);
    localparam logic [15:0]    DIV_LAST  = 16'(CLK_DIV - 1);

    poll_state_t    r_state;
    poll_state_t    w_nextState;
    logic [PCW-1:0] r_pollCnt;
    logic [15:0]    r_divCnt;
    logic [2:0]     r_bitCnt;
    logic [1:0]     r_sync0;
    logic [1:0]     r_sync1;
    logic [7:0]     r_cap0;
    logic [7:0]     r_cap1;
    logic [7:0]     r_buttons0;
    logic [7:0]     r_buttons1;
    logic           r_padLatch;
    logic           r_padClk;
    logic           w_pollTick;
    logic           w_timed;
    logic           w_divLast;
    logic           w_padLatchNxt;
    logic           w_padClkNxt;
    logic [7:0]     w_store0;
    logic [7:0]     w_store1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0 <= 2'b11;
            r_sync1 <= 2'b11;
        end else begin
            r_sync0 <= {r_sync0[0], i_pad_data0};
            r_sync1 <= {r_sync1[0], i_pad_data1};
        end
    end

    // Free-running interval counter; a tick that lands mid-poll is simply lost.
    assign w_pollTick = (r_pollCnt == POLL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pollCnt <= '0;
        end else if (w_pollTick) begin
            r_pollCnt <= '0;
        end else begin
            r_pollCnt <= r_pollCnt + 1'b1;
        end
    end

    assign w_timed   = (r_state == POLL_LATCH) || (r_state == POLL_CLK_LO) ||
                       (r_state == POLL_CLK_HI);
    assign w_divLast = (r_divCnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= POLL_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            POLL_IDLE:   if (w_pollTick) w_nextState = POLL_LATCH;
            POLL_LATCH:  if (w_divLast) w_nextState = POLL_CLK_LO;
            POLL_CLK_LO: if (w_divLast) w_nextState = POLL_CLK_HI;
            POLL_CLK_HI: if (w_divLast) w_nextState = (r_bitCnt == 3'd7) ? POLL_DONE : POLL_CLK_LO;
            POLL_DONE:   w_nextState = POLL_IDLE;
            default:     w_nextState = POLL_IDLE;
        endcase
    end

    // Pad outputs are decoded from the next state so the registered pins line up with r_state.
    always_comb begin
        w_padLatchNxt = 1'b0;
        w_padClkNxt   = 1'b1;
        case (w_nextState)
            POLL_LATCH:  w_padLatchNxt = 1'b1;
            POLL_CLK_LO: w_padClkNxt   = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_padLatch <= 1'b0;
            r_padClk   <= 1'b1;
        end else begin
            r_padLatch <= w_padLatchNxt;
            r_padClk   <= w_padClkNxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_divCnt <= '0;
            r_bitCnt <= '0;
            r_cap0   <= '0;
            r_cap1   <= '0;
        end else begin
            if (w_timed && !w_divLast) begin
                r_divCnt <= r_divCnt + 1'b1;
            end else begin
                r_divCnt <= '0;
            end
            if ((r_state == POLL_LATCH) && w_divLast) begin
                r_cap0[0] <= r_sync0[1];
                r_cap1[0] <= r_sync1[1];
                r_bitCnt  <= 3'd1;
            end else if ((r_state == POLL_CLK_HI) && w_divLast) begin
                r_cap0[r_bitCnt] <= r_sync0[1];
                r_cap1[r_bitCnt] <= r_sync1[1];
                r_bitCnt         <= r_bitCnt + 1'b1;
            end
        end
    end

`ifdef JOYPAD_DPAD_FILTER_EN
    assign w_store0 = dpad_filter(~r_cap0);
    assign w_store1 = dpad_filter(~r_cap1);
`else
    assign w_store0 = ~r_cap0;
    assign w_store1 = ~r_cap1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buttons0 <= '0;
            r_buttons1 <= '0;
        end else if (r_state == POLL_DONE) begin
            r_buttons0 <= w_store0;
            r_buttons1 <= w_store1;
        end
    end

    assign o_pad_latch = r_padLatch;
    assign o_pad_clk   = r_padClk;
    assign o_buttons0  = r_buttons0;
    assign o_buttons1  = r_buttons1;

endmodule

// File: rtl/nes_joypad_port.sv
// CPU-side NES controller registers ($4016 strobe/pad 0, $4017 pad 1) backed by a pad poll engine.
// Build option: JOYPAD_DPAD_FILTER_EN (handled inside nes_pad_poller).
module nes_joypad_port
    import nes_io_pkg::*;
#(
    parameter int CLK_DIV       = 100,
    parameter int POLL_INTERVAL = 357954
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ce,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_din,
    input  logic        i_mr,
    input  logic        i_mw,
    output logic [7:0]  o_dout,
    output logic        o_dout_en,
    output logic        o_pad_latch,
    output logic        o_pad_clk,
    input  logic        i_pad_data0,
    input  logic        i_pad_data1,
    output logic [7:0]  o_buttons0,
    output logic [7:0]  o_buttons1
);

    logic       r_strobe;
    logic [7:0] r_shift0;
    logic [7:0] r_shift1;
    logic       w_hit0;
    logic       w_hit1;
    logic       w_strobeWr;
    logic       w_read0;
    logic       w_read1;
    logic [7:0] w_buttons0;
    logic [7:0] w_buttons1;
    logic       w_unused;

    assign w_unused = ^i_din[7:1];

    nes_pad_poller #(
        .CLK_DIV       (CLK_DIV),
        .POLL_INTERVAL (POLL_INTERVAL)
    ) u_poller (
        .clk         (clk),
        .reset       (reset),
        .i_pad_data0 (i_pad_data0),
        .i_pad_data1 (i_pad_data1),
        .o_pad_latch (o_pad_latch),
        .o_pad_clk   (o_pad_clk),
        .o_buttons0  (w_buttons0),
        .o_buttons1  (w_buttons1)
    );

    assign w_hit0     = (i_addr == JOY1_ADDR);
    assign w_hit1     = (i_addr == JOY2_ADDR);
    assign w_strobeWr = i_ce && i_mw && w_hit0;
    assign w_read0    = i_ce && i_mr && w_hit0;
    assign w_read1    = i_ce && i_mr && w_hit1;

    // Strobe high keeps reloading from the snapshot; strobe low lets each read shift out one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe <= 1'b0;
            r_shift0 <= 8'h00;
            r_shift1 <= 8'h00;
        end else begin
            if (w_strobeWr) begin
                r_strobe <= i_din[0];
            end
            if (r_strobe) begin
                r_shift0 <= w_buttons0;
                r_shift1 <= w_buttons1;
            end else begin
                if (w_read0) begin
                    r_shift0 <= {1'b1, r_shift0[7:1]};
                end
                if (w_read1) begin
                    r_shift1 <= {1'b1, r_shift1[7:1]};
                end
            end
        end
    end

    assign o_dout_en = (w_hit0 || w_hit1) && i_mr;

    always_comb begin
        o_dout = 8'h00;
        if (o_dout_en) begin
            o_dout = {OPEN_BUS, 4'b0000, (w_hit1 ? r_shift1[0] : r_shift0[0])};
        end
    end

    assign o_buttons0 = w_buttons0;
    assign o_buttons1 = w_buttons1;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port: serial pad models, CPU read queue, poll timing checks.
// Define JOYPAD_DPAD_FILTER_EN on both bench and RTL to check the D-pad filter build.
module tb_nes_joypad_port;

    localparam int CLK_DIV       = 4;
    localparam int POLL_INTERVAL = 200;
    localparam int POLL_LIMIT    = 4 * POLL_INTERVAL;
    localparam int CLK_LIMIT     = 20 * CLK_DIV + 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_ce = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic [7:0]  i_din = 8'h00;
    logic        i_mr = 1'b1;
    logic        i_mw = 1'b0;
    logic [7:0]  o_dout;
    logic        o_dout_en;
    logic        o_pad_latch;
    logic        o_pad_clk;
    logic        i_pad_data0;
    logic        i_pad_data1;
    logic [7:0]  o_buttons0;
    logic [7:0]  o_buttons1;

    logic [7:0]  pressed0 = 8'h00;
    logic [7:0]  pressed1 = 8'h00;
    logic [7:0]  padSr0 = 8'h00;
    logic [7:0]  padSr1 = 8'h00;

    int          nVectors = 0;
    int          nMiscompares = 0;

    logic        modelStrobe = 1'b0;
    logic [7:0]  snap [2];
    logic [7:0]  latched [2];
    int          idx [2];
    logic [7:0]  expQ [$];

    always #5 clk = ~clk;

    nes_joypad_port #(
        .CLK_DIV       (CLK_DIV),
        .POLL_INTERVAL (POLL_INTERVAL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_ce        (i_ce),
        .i_addr      (i_addr),
        .i_din       (i_din),
        .i_mr        (i_mr),
        .i_mw        (i_mw),
        .o_dout      (o_dout),
        .o_dout_en   (o_dout_en),
        .o_pad_latch (o_pad_latch),
        .o_pad_clk   (o_pad_clk),
        .i_pad_data0 (i_pad_data0),
        .i_pad_data1 (i_pad_data1),
        .o_buttons0  (o_buttons0),
        .o_buttons1  (o_buttons1)
    );

    // 4021-style pads: parallel load on latch, shift on pad_clk rise, active-low serial output.
    always @(posedge o_pad_latch) begin
        padSr0 = pressed0;
        padSr1 = pressed1;
    end

    always @(posedge o_pad_clk) begin
        if (o_pad_latch !== 1'b1) begin
            padSr0 = {1'b0, padSr0[7:1]};
            padSr1 = {1'b0, padSr1[7:1]};
        end
    end

    assign i_pad_data0 = ~padSr0[0];
    assign i_pad_data1 = ~padSr1[0];

    function automatic logic [7:0] padModel(input logic [7:0] p);
        logic [7:0] r;
        r = p;
`ifdef JOYPAD_DPAD_FILTER_EN
        if (p[4] && p[5]) r[5:4] = 2'b00;
        if (p[6] && p[7]) r[7:6] = 2'b00;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic noteTimeout(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    // One CPU bus cycle; the reference model decides the byte a read must return.
    task automatic applyStimulus(input bit isWrite, input logic [15:0] a, input logic [7:0] d,
                                 input bit withCe);
        int p;
        logic b;
        @(posedge clk);
        #1;
        i_addr = a;
        i_din  = d;
        i_mw   = isWrite;
        i_mr   = !isWrite;
        i_ce   = withCe;
        if (withCe) begin
            if (isWrite && a == 16'h4016) begin
                if (modelStrobe) begin
                    latched[0] = snap[0];
                    latched[1] = snap[1];
                    idx[0] = 0;
                    idx[1] = 0;
                end
                modelStrobe = d[0];
            end else if (!isWrite && (a == 16'h4016 || a == 16'h4017)) begin
                p = (a == 16'h4017) ? 1 : 0;
                if (modelStrobe) begin
                    b = snap[p][0];
                end else begin
                    b = (idx[p] < 8) ? latched[p][idx[p]] : 1'b1;
                    idx[p]++;
                end
                expQ.push_back({3'b010, 4'b0000, b});
            end
        end
        @(posedge clk);
        #1;
        i_ce   = 1'b0;
        i_mw   = 1'b0;
        i_mr   = 1'b1;
        i_addr = 16'h0000;
    endtask

    // Monitor: every ce-qualified bus cycle is judged here, reads against the scoreboard queue.
    always @(negedge clk) begin
        if (i_ce) begin
            if (o_dout_en) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedRead", {8'h00, o_dout}, 16'hFFFF);
                end else begin
                    checkOutput("cpuRead", {8'h00, o_dout}, {8'h00, expQ.pop_front()});
                end
            end else if (i_mr && (i_addr == 16'h4016 || i_addr == 16'h4017)) begin
                checkOutput("readEnable", 16'(o_dout_en), 16'h0001);
            end else begin
                checkOutput("idleDout", {8'h00, o_dout}, 16'h0000);
            end
        end
    end

    task automatic waitLatchStart(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_pad_latch === 1'b1 && n < POLL_LIMIT);
        while (o_pad_latch !== 1'b1 && n < POLL_LIMIT) begin
            @(negedge clk);
            n++;
        end
        ok = (n < POLL_LIMIT);
    endtask

    task automatic waitPoll(input logic [7:0] e0, input logic [7:0] e1);
        bit   ok;
        int   n;
        int   latchCycles;
        int   rises;
        int   falls;
        logic prevClk;
        waitLatchStart(ok);
        if (!ok) begin
            noteTimeout("pollStart");
            return;
        end
        latchCycles = 0;
        while (o_pad_latch === 1'b1 && latchCycles < CLK_LIMIT) begin
            latchCycles++;
            @(negedge clk);
        end
        checkOutput("latchWidth", 16'(latchCycles), 16'(CLK_DIV));
        rises = 0;
        falls = 0;
        prevClk = 1'b1;
        n = 0;
        while (rises < 7 && n < CLK_LIMIT) begin
            if (prevClk === 1'b1 && o_pad_clk === 1'b0) falls++;
            if (prevClk === 1'b0 && o_pad_clk === 1'b1) rises++;
            prevClk = o_pad_clk;
            if (rises < 7) begin
                @(negedge clk);
                n++;
            end
        end
        if (rises < 7) begin
            noteTimeout("padClkPulses");
            return;
        end
        repeat (CLK_DIV + 1) begin
            @(negedge clk);
            if (prevClk === 1'b1 && o_pad_clk === 1'b0) falls++;
            prevClk = o_pad_clk;
        end
        checkOutput("padClkLowPulses", 16'(falls), 16'd7);
        checkOutput("buttons0", {8'h00, o_buttons0}, {8'h00, e0});
        checkOutput("buttons1", {8'h00, o_buttons1}, {8'h00, e1});
        snap[0] = e0;
        snap[1] = e1;
    endtask

    task automatic modelReset();
        modelStrobe = 1'b0;
        for (int p = 0; p < 2; p++) begin
            snap[p]    = 8'h00;
            latched[p] = 8'h00;
            idx[p]     = 0;
        end
    endtask

    initial begin
        bit   ok;
        int   falls;
        int   n;
        logic prevClk;
        logic [15:0] a;

        modelReset();
        pressed0 = 8'h09;
        pressed1 = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("resetLatch", 16'(o_pad_latch), 16'h0000);
        checkOutput("resetPadClk", 16'(o_pad_clk), 16'h0001);
        checkOutput("resetButtons0", {8'h00, o_buttons0}, 16'h0000);
        checkOutput("resetButtons1", {8'h00, o_buttons1}, 16'h0000);
        reset = 1'b0;

        // Shift registers come out of reset empty: zeros first, then the trailing ones.
        applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1);
        applyStimulus(1'b0, 16'h4017, 8'h00, 1'b1);

        $display("[TB] poll capture: A+Start on pad 0");
        waitPoll(padModel(8'h09), padModel(8'h00));

        $display("[TB] serial read of pad 0");
        applyStimulus(1'b1, 16'h4016, 8'h01, 1'b1);
        applyStimulus(1'b1, 16'h4016, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1);

        $display("[TB] strobe held");
        applyStimulus(1'b1, 16'h4016, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1);
        applyStimulus(1'b1, 16'h4016, 8'hFE, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1);

        $display("[TB] independent pads");
        pressed1 = 8'hA6;
        waitPoll(padModel(pressed0), padModel(pressed1));
        applyStimulus(1'b1, 16'h4016, 8'h01, 1'b1);
        applyStimulus(1'b1, 16'h4017, 8'h00, 1'b1);
        applyStimulus(1'b1, 16'h4016, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 16'h4017, 8'h00, 1'b1);
            applyStimulus(1'b0, 16'h4016, 8'h00, (i % 3) != 1);
            applyStimulus(1'b0, 16'h4017, 8'h00, (i % 4) != 2);
        end
        applyStimulus(1'b0, 16'h4015, 8'h00, 1'b1);
        applyStimulus(1'b1, 16'h4017, 8'h01, 1'b1);
        applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1);

        $display("[TB] reset during bit 3 clock-low phase");
        waitLatchStart(ok);
        if (!ok) begin
            noteTimeout("midPollStart");
        end else begin
            falls = 0;
            prevClk = 1'b1;
            n = 0;
            while (falls < 3 && n < CLK_LIMIT) begin
                @(negedge clk);
                n++;
                if (prevClk === 1'b1 && o_pad_clk === 1'b0) falls++;
                prevClk = o_pad_clk;
            end
            if (falls < 3) noteTimeout("midPollClkLo");
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            modelReset();
            checkOutput("abortPadClk", 16'(o_pad_clk), 16'h0001);
            checkOutput("abortLatch", 16'(o_pad_latch), 16'h0000);
            checkOutput("abortButtons0", {8'h00, o_buttons0}, 16'h0000);
            checkOutput("abortButtons1", {8'h00, o_buttons1}, 16'h0000);
        end
        applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1);
        waitPoll(padModel(pressed0), padModel(pressed1));

        $display("[TB] D-pad conflict on pad 0");
        pressed0 = 8'h31;
        pressed1 = 8'hC4;
        waitPoll(padModel(pressed0), padModel(pressed1));
        applyStimulus(1'b1, 16'h4016, 8'h01, 1'b1);
        applyStimulus(1'b1, 16'h4016, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 16'h4016, 8'h00, 1'b1);
            applyStimulus(1'b0, 16'h4017, 8'h00, 1'b1);
        end

        $display("[TB] randomized traffic");
        for (int r = 0; r < 6; r++) begin
            pressed0 = 8'($urandom);
            pressed1 = 8'($urandom);
            waitPoll(padModel(pressed0), padModel(pressed1));
            applyStimulus(1'b1, 16'h4016, 8'h01, 1'b1);
            applyStimulus(1'b1, 16'h4016, 8'h00, 1'b1);
            for (int k = 0; k < 30; k++) begin
                case ($urandom_range(0, 4))
                    0, 1:    a = 16'h4016;
                    2, 3:    a = 16'h4017;
                    default: a = 16'h4015;
                endcase
                applyStimulus($urandom_range(0, 5) == 0, a, 8'($urandom), $urandom_range(0, 5) != 0);
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 16'(expQ.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
